// File: rtl/alu_pkg.sv
// Shared opcode, state and status-flag definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_OVF   = 3;
  localparam int unsigned FLAG_DIVZ  = 4;
  localparam int unsigned FLAG_W     = 5;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue-side and writeback-side valid/ready bundle of the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             overflow;
  logic             div_zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, result_hi,
           zero, neg, carry, overflow, div_zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, result_hi,
           zero, neg, carry, overflow, div_zero
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned MSB   = WIDTH - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] lo_q, hi_q, b_q;
  logic             div_q, dz_q;

  logic [WIDTH-1:0] cur_lo, cur_hi, cur_b, nxt_lo, nxt_hi, shifted;
  logic             cur_div, step_en, ge;
  logic [WIDTH:0]   prod_sum;

  // The first step runs on the start edge straight from the operand inputs,
  // so the final iteration lands while the counter reads 1.
  always_comb begin
    cur_lo   = start ? a      : lo_q;
    cur_hi   = start ? '0     : hi_q;
    cur_b    = start ? b      : b_q;
    cur_div  = start ? is_div : div_q;
    step_en  = start || (cnt_q > CNT_W'(1));
    prod_sum = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
    shifted  = {cur_hi[MSB-1:0], cur_lo[MSB]};
    ge       = {cur_hi, cur_lo[MSB]} >= {1'b0, cur_b};
    if (cur_div) begin
      nxt_hi = ge ? (shifted - cur_b) : shifted;
      nxt_lo = {cur_lo[MSB-1:0], ge};
    end else begin
      nxt_hi = prod_sum[WIDTH:1];
      nxt_lo = {prod_sum[0], cur_lo[MSB:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= CNT_W'(WIDTH);
        b_q   <= b;
        div_q <= is_div;
        dz_q  <= is_div && (b == '0);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (step_en) begin
        lo_q <= nxt_lo;
        hi_q <= nxt_hi;
      end
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == CNT_W'(1));
  assign lo       = lo_q;
  assign hi       = hi_q;
  assign div_zero = dz_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith ops plus iterative mul/div.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int unsigned MSB = WIDTH - 1;

  state_t state, state_nxt;

  logic              accept, start_iter, op_div_q;
  logic              md_busy, md_done, md_dz;
  logic [WIDTH-1:0]  md_lo, md_hi;
  logic [WIDTH-1:0]  result_q, result_hi_q, sc_res, diff;
  logic [WIDTH:0]    sum;
  logic              sc_carry, sc_ovf;
  logic [FLAG_W-1:0] flags_q, sc_flags, md_flags;

  assign accept     = bus.in_valid && (state == IDLE);
  assign start_iter = accept && is_iter(bus.op);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_iter),
    .is_div   (bus.op == OP_DIV),
    .a        (bus.a),
    .b        (bus.b),
    .busy     (md_busy),
    .done     (md_done),
    .lo       (md_lo),
    .hi       (md_hi),
    .div_zero (md_dz)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_iter(bus.op) ? BUSY : DONE;
      BUSY: begin
        if (md_done)       state_nxt = DONE;
        else if (!md_busy) state_nxt = IDLE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = result_q;
    bus.result_hi = result_hi_q;
    bus.zero      = flags_q[FLAG_ZERO];
    bus.neg       = flags_q[FLAG_NEG];
    bus.carry     = flags_q[FLAG_CARRY];
    bus.overflow  = flags_q[FLAG_OVF];
    bus.div_zero  = flags_q[FLAG_DIVZ];
  end

  always_comb begin
    sum      = {1'b0, bus.a} + {1'b0, bus.b};
    diff     = bus.a - bus.b;
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res   = sum[MSB:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        sc_res   = diff;
        sc_carry = bus.a < bus.b;
        sc_ovf   = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_SHL: begin
        sc_res   = {bus.a[MSB-1:0], 1'b0};
        sc_carry = bus.a[MSB];
      end
      OP_SHR: begin
        sc_res   = {1'b0, bus.a[MSB:1]};
        sc_carry = bus.a[0];
      end
      OP_ROL:  sc_res = {bus.a[MSB-1:0], bus.a[MSB]};
      OP_ROR:  sc_res = {bus.a[0], bus.a[MSB:1]};
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_NOR:  sc_res = ~(bus.a | bus.b);
      OP_NAND: sc_res = ~(bus.a & bus.b);
      OP_XNOR: sc_res = ~(bus.a ^ bus.b);
      OP_GT:   sc_res = WIDTH'(bus.a > bus.b);
      OP_EQ:   sc_res = WIDTH'(bus.a == bus.b);
      default: sc_res = '0;
    endcase

    sc_flags             = '0;
    sc_flags[FLAG_ZERO]  = (sc_res == '0);
    sc_flags[FLAG_NEG]   = sc_res[MSB];
    sc_flags[FLAG_CARRY] = sc_carry;
    sc_flags[FLAG_OVF]   = sc_ovf;

    md_flags             = '0;
    md_flags[FLAG_ZERO]  = (md_lo == '0);
    md_flags[FLAG_NEG]   = md_lo[MSB];
    md_flags[FLAG_CARRY] = !op_div_q && (md_hi != '0);
    md_flags[FLAG_DIVZ]  = md_dz;
  end

  // Results only change on accept of a single-cycle op or on the final
  // mul/div iteration, so they hold for the whole DONE backpressure window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      op_div_q    <= 1'b0;
    end else if (accept) begin
      op_div_q <= (bus.op == OP_DIV);
      if (!is_iter(bus.op)) begin
        result_q    <= sc_res;
        result_hi_q <= '0;
        flags_q     <= sc_flags;
      end
    end else if ((state == BUSY) && md_done) begin
      result_q    <= md_lo;
      result_hi_q <= md_hi;
      flags_q     <= md_flags;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint unsigned res;
    longint unsigned hi;
    bit z, n, c, v, dz;
  } exp_t;

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic z, n, c, v, dz, rdy, vld;
  } obs_t;

  obs_t last_obs;
  int   last_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit msb(input longint unsigned x, input int unsigned w);
    return ((x >> (w - 1)) & 64'd1) != 0;
  endfunction

  function automatic exp_t model(input int unsigned w, input logic [3:0] op,
                                 input longint unsigned a_in, input longint unsigned b_in);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned a = a_in & m;
    longint unsigned b = b_in & m;
    longint unsigned t;
    exp_t e;
    e = '{default: 0};
    case (op)
      4'h0: begin
        t = a + b; e.res = t & m; e.c = (t >> w) != 0;
        e.v = (msb(a, w) == msb(b, w)) && (msb(e.res, w) != msb(a, w));
      end
      4'h1: begin
        e.res = (a - b) & m; e.c = a < b;
        e.v = (msb(a, w) != msb(b, w)) && (msb(e.res, w) != msb(a, w));
      end
      4'h2: begin
        t = a * b; e.res = t & m; e.hi = t >> w; e.c = e.hi != 0;
      end
      4'h3: begin
        if (b == 0) begin e.res = m; e.hi = a; e.dz = 1; end
        else begin e.res = a / b; e.hi = a % b; end
      end
      4'h4: begin e.res = (a << 1) & m; e.c = msb(a, w); end
      4'h5: begin e.res = a >> 1; e.c = (a & 1) != 0; end
      4'h6: e.res = ((a << 1) | (a >> (w - 1))) & m;
      4'h7: e.res = (a >> 1) | ((a & 1) << (w - 1));
      4'h8: e.res = a & b;
      4'h9: e.res = a | b;
      4'hA: e.res = a ^ b;
      4'hB: e.res = ~(a | b) & m;
      4'hC: e.res = ~(a & b) & m;
      4'hD: e.res = ~(a ^ b) & m;
      4'hE: e.res = (a > b) ? 1 : 0;
      default: e.res = (a == b) ? 1 : 0;
    endcase
    e.z = (e.res == 0);
    e.n = msb(e.res, w);
    return e;
  endfunction

  task automatic set_in(input bit wide, input logic v, input logic [3:0] op,
                        input longint unsigned a, input longint unsigned b);
    if (wide) begin
      bus16.in_valid = v; bus16.op = op; bus16.a = a[15:0]; bus16.b = b[15:0];
    end else begin
      bus8.in_valid = v; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end
  endtask

  task automatic set_ordy(input bit wide, input logic v);
    if (wide) bus16.out_ready = v;
    else      bus8.out_ready = v;
  endtask

  function automatic obs_t sample(input bit wide);
    obs_t o;
    if (wide) begin
      o.res = {48'd0, bus16.result}; o.hi = {48'd0, bus16.result_hi};
      o.z = bus16.zero; o.n = bus16.neg; o.c = bus16.carry; o.v = bus16.overflow;
      o.dz = bus16.div_zero; o.rdy = bus16.in_ready; o.vld = bus16.out_valid;
    end else begin
      o.res = {56'd0, bus8.result}; o.hi = {56'd0, bus8.result_hi};
      o.z = bus8.zero; o.n = bus8.neg; o.c = bus8.carry; o.v = bus8.overflow;
      o.dz = bus8.div_zero; o.rdy = bus8.in_ready; o.vld = bus8.out_valid;
    end
    return o;
  endfunction

  task automatic check_out(input obs_t o, input exp_t e);
    chk("result",    o.res, e.res);
    chk("result_hi", o.hi,  e.hi);
    chk("zero",      o.z,   e.z);
    chk("neg",       o.n,   e.n);
    chk("carry",     o.c,   e.c);
    chk("overflow",  o.v,   e.v);
    chk("div_zero",  o.dz,  e.dz);
  endtask

  task automatic run_op(input bit wide, input logic [3:0] op, input longint unsigned a,
                        input longint unsigned b, input int hold);
    int unsigned w = wide ? 16 : 8;
    int          exp_lat = (op == 4'h2 || op == 4'h3) ? int'(w) + 1 : 1;
    exp_t        e = model(w, op, a, b);
    obs_t        o;
    int          lat;
    bit          rdy_bad = 1'b0;
    @(negedge clk);
    o = sample(wide);
    chk("in_ready_idle", o.rdy, 1'b1);
    set_in(wide, 1'b1, op, a, b);
    set_ordy(wide, 1'b0);
    @(posedge clk); #1;
    set_in(wide, 1'b0, 4'($urandom), $urandom, $urandom);
    lat = 1;
    o = sample(wide);
    while (o.vld !== 1'b1 && lat < 40) begin
      if (o.rdy !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
      o = sample(wide);
    end
    chk("latency", lat, exp_lat);
    chk("in_ready_busy", rdy_bad, 1'b0);
    check_out(o, e);
    last_obs = o;
    last_lat = lat;
    repeat (hold) begin
      @(negedge clk);
      set_in(wide, 1'b1, 4'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      o = sample(wide);
      chk("held_valid", o.vld, 1'b1);
      chk("held_ready", o.rdy, 1'b0);
      check_out(o, e);
    end
    @(negedge clk);
    set_in(wide, 1'b0, 4'($urandom), $urandom, $urandom);
    set_ordy(wide, 1'b1);
    @(posedge clk); #1;
    set_ordy(wide, 1'b0);
    o = sample(wide);
    chk("release_valid", o.vld, 1'b0);
    chk("release_ready", o.rdy, 1'b1);
  endtask

  initial begin
    obs_t o;
    bit   seen;
    set_in(1'b0, 1'b0, 4'h0, 0, 0);
    set_in(1'b1, 1'b0, 4'h0, 0, 0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    o = sample(1'b0);
    chk("rst_valid", o.vld, 1'b0);
    chk("rst_ready", o.rdy, 1'b1);
    check_out(o, '{default: 0});
    @(negedge clk) rst_n = 1'b1;

    run_op(1'b0, OP_ADD, 'hFF, 'h01, 0);
    chk("add_ff_01_res", last_obs.res, 64'h00);
    chk("add_ff_01_c", last_obs.c, 1'b1);
    run_op(1'b0, OP_ADD, 'h7F, 'h01, 0);
    chk("add_7f_01_v", last_obs.v, 1'b1);
    run_op(1'b0, OP_SUB, 'h05, 'h07, 0);
    chk("sub_05_07_res", last_obs.res, 64'hFE);
    run_op(1'b0, OP_MUL, 200, 3, 0);
    chk("mul_lo", last_obs.res, 64'h58);
    chk("mul_hi", last_obs.hi, 64'h02);
    chk("mul_lat", last_lat, 9);
    run_op(1'b0, OP_DIV, 100, 7, 0);
    chk("div_q", last_obs.res, 64'h0E);
    chk("div_r", last_obs.hi, 64'h02);
    run_op(1'b0, OP_DIV, 'h37, 0, 0);
    chk("div0_q", last_obs.res, 64'hFF);
    chk("div0_r", last_obs.hi, 64'h37);
    chk("div0_flag", last_obs.dz, 1'b1);
    run_op(1'b0, OP_SHR, 'h81, 'h00, 5);
    chk("shr_res", last_obs.res, 64'h40);

    for (int i = 0; i < 16; i++) run_op(1'b0, 4'(i), $urandom, $urandom, 0);
    for (int i = 0; i < 40; i++)
      run_op(1'b0, 4'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));
    run_op(1'b0, OP_SUB, 'h80, 'h01, 0);
    run_op(1'b0, OP_SUB, 'h00, 'h00, 0);

    // Abort a divide in its fourth BUSY cycle.
    run_op(1'b0, OP_OR, 'h5A, 'h81, 0);
    @(negedge clk);
    set_in(1'b0, 1'b1, OP_DIV, 100, 7);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 4'h0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    o = sample(1'b0);
    chk("abort_valid", o.vld, 1'b0);
    chk("abort_ready", o.rdy, 1'b1);
    check_out(o, '{default: 0});
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus8.out_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_result", seen, 1'b0);

    run_op(1'b1, OP_MUL, 'hFFFF, 'hFFFF, 0);
    chk("mul16_lo", last_obs.res, 64'h0001);
    chk("mul16_hi", last_obs.hi, 64'hFFFE);
    chk("mul16_lat", last_lat, 17);
    run_op(1'b1, OP_DIV, 'hFFFF, 'h0003, 1);
    run_op(1'b1, OP_DIV, 'h1234, 0, 0);
    for (int i = 0; i < 24; i++)
      run_op(1'b1, 4'($urandom), $urandom, $urandom, int'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
